// File: rtl/pcp_stream_pkg.sv
// Shared types, default sizes and TDATA field extractors for the PCP vector stream receiver.
package pcp_stream_pkg;

  typedef enum logic [1:0] {S_IDX, S_VAL, S_HOLD, S_DRAIN} pcp_state_e;

  localparam int PCP_TDATA_W     = 512;
  localparam int PCP_NUM_ENTRIES = 12;
  localparam int PCP_IDX_W       = 8;
  localparam int PCP_VALUE_W     = 16;

  function automatic logic [PCP_IDX_W-1:0] pcp_idx(input logic [PCP_TDATA_W-1:0] tdata);
    return tdata[PCP_IDX_W-1:0];
  endfunction

  function automatic logic [PCP_VALUE_W-1:0] pcp_val(input logic [PCP_TDATA_W-1:0] tdata);
    return tdata[PCP_VALUE_W-1:0];
  endfunction

endpackage

// File: rtl/pcp_vector_buf.sv
// Register array holding one PCP vector; single write port, whole array exposed as a flat bus.
module pcp_vector_buf #(
  parameter int NUM_ENTRIES = 12,
  parameter int VALUE_W     = 16,
  parameter int ADDR_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [VALUE_W-1:0]             wr_data,
  output logic [NUM_ENTRIES*VALUE_W-1:0] rd_data
);

  logic [NUM_ENTRIES-1:0][VALUE_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/pcp_vector_rx.sv
// AXI4-Stream receiver assembling {index, value} beat pairs into a PCP vector.
// Optional PCP_RX_STATS_EN adds completed-vector and error-event counters.
module pcp_vector_rx
  import pcp_stream_pkg::*;
#(
  parameter int TDATA_W     = PCP_TDATA_W,
  parameter int NUM_ENTRIES = PCP_NUM_ENTRIES,
  parameter int IDX_W       = PCP_IDX_W,
  parameter int VALUE_W     = PCP_VALUE_W
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [TDATA_W-1:0]             s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [NUM_ENTRIES*VALUE_W-1:0] vec_data,
  output logic                           vec_valid,
  input  logic                           vec_ready,
  output logic                           err_seq,
  output logic                           err_len
`ifdef PCP_RX_STATS_EN
  ,
  output logic [15:0]                    vec_cnt,
  output logic [15:0]                    err_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_ENTRIES);

  pcp_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tready_p1;
  logic             vld_p1;
  logic             err_seq_p1, err_len_p1;
  logic             beat_acc, last_ent;
  logic             wr_en, set_seq, set_len, vec_done;
  logic [IDX_W-1:0] beat_idx;

  assign beat_acc = s_axis_tvalid && tready_p1;
  assign beat_idx = pcp_idx(s_axis_tdata);
  assign last_ent = (cnt == CNT_W'(NUM_ENTRIES - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    set_seq   = 1'b0;
    set_len   = 1'b0;
    vec_done  = 1'b0;
    case (state)
      S_IDX: begin
        // A tlast on an index beat ends the packet there, so no drain is needed
        if (beat_acc) begin
          if (s_axis_tlast) begin
            set_len = 1'b1;
            cnt_nxt = '0;
          end else if (beat_idx == IDX_W'(cnt) + IDX_W'(1)) begin
            state_nxt = S_VAL;
          end else begin
            set_seq   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_VAL: begin
        if (beat_acc) begin
          wr_en = 1'b1;
          if (s_axis_tlast && last_ent) begin
            vec_done  = 1'b1;
            state_nxt = S_HOLD;
          end else if (s_axis_tlast) begin
            set_len   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_IDX;
          end else if (last_ent) begin
            set_len   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_DRAIN;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = S_IDX;
          end
        end
      end
      S_DRAIN: begin
        if (beat_acc && s_axis_tlast) begin
          cnt_nxt   = '0;
          state_nxt = S_IDX;
        end
      end
      S_HOLD: begin
        if (vec_ready) begin
          cnt_nxt   = '0;
          state_nxt = S_IDX;
        end
      end
      default: state_nxt = S_IDX;
    endcase
  end

  // ---- registered control: tready/valid follow the next state so both are glitch-free ----
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= S_IDX;
      cnt        <= '0;
      tready_p1  <= 1'b0;
      vld_p1     <= 1'b0;
      err_seq_p1 <= 1'b0;
      err_len_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tready_p1  <= (state_nxt != S_HOLD);
      vld_p1     <= (state_nxt == S_HOLD);
      err_seq_p1 <= err_seq_p1 | set_seq;
      err_len_p1 <= err_len_p1 | set_len;
    end
  end

  assign s_axis_tready = tready_p1;
  assign vec_valid     = vld_p1;
  assign err_seq       = err_seq_p1;
  assign err_len       = err_len_p1;

  pcp_vector_buf #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .VALUE_W     (VALUE_W),
    .ADDR_W      (CNT_W)
  ) u_buf (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (wr_en),
    .wr_addr (cnt),
    .wr_data (pcp_val(s_axis_tdata)),
    .rd_data (vec_data)
  );

`ifdef PCP_RX_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // An aborted vector raises exactly one of set_seq/set_len, giving one event per abort
  always_ff @(posedge aclk) begin
    if (areset) begin
      vec_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (vec_done) vec_cnt <= vec_cnt + 16'd1;
      if (set_seq || set_len) err_cnt <= sat_inc16(err_cnt);
    end
  end
`endif

endmodule
